// File: rtl/reg_file_param.sv
// reg_file_param: parametrised MIPS register file.
//   Two combinational read ports with same-cycle write-through bypass, one synchronous
//   write port. After reset a sequencer zeroes the array one entry per edge, so the
//   storage carries no reset and stays RAM-inferable. `ready` holds off the pipeline
//   until the sweep (and the optional preset load) has finished.
//
// Optional feature macro: REGFILE_PRESET_EN
//   defined     : after the clear, three edges load $s1=4, $s2=1, $s7=17
//   not defined : the clear goes straight to normal operation
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous, active-high; dominates all other inputs
//   readReg1/2     read indices
//   readData1/2    read data (combinational)
//   writeRegister  write index
//   writeData      write data
//   regWrite       write enable, sampled on posedge
//   ready          1 while the array is initialised and live
//   writeDropped   registered 1-cycle pulse: regWrite was seen while ready==0
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  output logic              ready,
  output logic              writeDropped
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StClear, StPreset, StRun} state_e;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            stateQ, stateD;
  logic [ADDR_W-1:0] ptrQ, ptrD;
  logic              readyQ;
  logic              droppedQ;

  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;

  // A write that actually lands in the array (index 0 is discarded when hardwired).
  logic wrLegal;
  assign wrLegal = regWrite && !(ZERO_REG && (writeRegister == '0));

`ifdef REGFILE_PRESET_EN
  logic [1:0]  presetQ, presetD;
  int unsigned presetAddr;
  int unsigned presetVal;

  always_comb begin
    presetAddr = 0;
    presetVal  = 0;
    unique case (presetQ)
      2'd0:    begin presetAddr = 17; presetVal = 4;  end
      2'd1:    begin presetAddr = 18; presetVal = 1;  end
      2'd2:    begin presetAddr = 23; presetVal = 17; end
      default: begin presetAddr = 0;  presetVal = 0;  end
    endcase
  end
`endif

  // Next-state and the single array write port, shared by clear, preset and run.
  always_comb begin
    stateD  = stateQ;
    ptrD    = ptrQ;
    memWe   = 1'b0;
    memAddr = ptrQ;
    memData = '0;
`ifdef REGFILE_PRESET_EN
    presetD = presetQ;
`endif
    unique case (stateQ)
      StClear: begin
        memWe = 1'b1;
        ptrD  = ptrQ + ADDR_W'(1);
        if (ptrQ == ADDR_W'(DEPTH - 1)) begin
`ifdef REGFILE_PRESET_EN
          stateD = StPreset;
`else
          stateD = StRun;
`endif
        end
      end
      StPreset: begin
`ifdef REGFILE_PRESET_EN
        presetD = presetQ + 2'd1;
        // Entries beyond the array are skipped but still take their cycle.
        if (presetAddr < DEPTH) begin
          memWe   = 1'b1;
          memAddr = ADDR_W'(presetAddr);
          memData = DATA_W'(presetVal);
        end
        if (presetQ == 2'd2) stateD = StRun;
`else
        stateD = StRun;
`endif
      end
      StRun: begin
        memWe   = wrLegal;
        memAddr = writeRegister;
        memData = writeData;
      end
      default: stateD = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StClear;
      ptrQ     <= '0;
      readyQ   <= 1'b0;
      droppedQ <= 1'b0;
`ifdef REGFILE_PRESET_EN
      presetQ  <= 2'd0;
`endif
    end else begin
      stateQ   <= stateD;
      ptrQ     <= ptrD;
      readyQ   <= (stateD == StRun);
      droppedQ <= regWrite && !readyQ;
`ifdef REGFILE_PRESET_EN
      presetQ  <= presetD;
`endif
    end
  end

  // Storage has no reset; the clear sweep initialises it. Reset blocks writes this edge.
  always_ff @(posedge clk) begin
    if (!reset && memWe) begin
      mem[memAddr] <= memData;
    end
  end

  always_comb begin
    readData1 = '0;
    if (readyQ && !(ZERO_REG && (readReg1 == '0))) begin
      if (wrLegal && (writeRegister == readReg1)) readData1 = writeData;
      else                                        readData1 = mem[readReg1];
    end
  end

  always_comb begin
    readData2 = '0;
    if (readyQ && !(ZERO_REG && (readReg2 == '0))) begin
      if (wrLegal && (writeRegister == readReg2)) readData2 = writeData;
      else                                        readData2 = mem[readReg2];
    end
  end

  assign ready        = readyQ;
  assign writeDropped = droppedQ;

endmodule
